vga_fb_fetch_arbiter: RTL and testbench

- Shares one single-port framebuffer memory between the VGA scanout path and a drawing client (CPU or blitter).
- Watches the x/y counters from the VGA timing generator. At the end of each active line it fetches the next line's words into a double-banked line buffer.
- The display fetch has absolute priority. The client gets single-word accesses in idle gaps through a req/gnt handshake.
- Runs in the 40 MHz pixel clock domain, between vga_timing and the framebuffer RAM/line buffer.

---
 rtl/vga_fb_fetch_arbiter_if.sv | 39 +++
 rtl/vga_fb_fetch_arbiter.sv | 115 +++++++++++
 tb/tb_vga_fb_fetch_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_fetch_arbiter_if.sv
// rtl/vga_fb_fetch_arbiter_if.sv - client, framebuffer memory and line-buffer buses of the fetch arbiter
interface vga_fb_fetch_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LB_AW  = 6
);
    logic              cli_req;
    logic              cli_we;
    logic [ADDR_W-1:0] cli_addr;
    logic [DATA_W-1:0] cli_wdata;
    logic              cli_gnt;
    logic              cli_rvalid;
    logic [DATA_W-1:0] cli_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              lb_we;
    logic              lb_bank;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W-1:0] lb_wdata;

    modport slave (
        input  cli_req, cli_we, cli_addr, cli_wdata, mem_rdata,
        output cli_gnt, cli_rvalid, cli_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata,
        output lb_we, lb_bank, lb_addr, lb_wdata
    );

    modport master (
        output cli_req, cli_we, cli_addr, cli_wdata, mem_rdata,
        input  cli_gnt, cli_rvalid, cli_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        input  lb_we, lb_bank, lb_addr, lb_wdata
    );
endinterface

// File: rtl/vga_fb_fetch_arbiter.sv
// rtl/vga_fb_fetch_arbiter.sv - shares the framebuffer between line prefetch and a client port
module vga_fb_fetch_arbiter #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int V_TOTAL    = 628,
    parameter int LINE_WORDS = 50,
    parameter int LB_AW      = 6,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FB_BASE    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  fetch_en,
    vga_fb_fetch_arbiter_if.slave bus,
    output logic                  fetch_busy,
    output logic                  fetch_done,
    output logic                  err_overrun
);
    typedef enum logic [1:0] {IDLE, CLIENT, FETCH, DRAIN} state_t;

    state_t            state;
    logic              pending;
    logic [LB_AW-1:0]  idx;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] fetch_start;

    logic [9:0]        line_next;
    logic              trig;
    logic [ADDR_W-1:0] start_addr;

    assign line_next  = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    assign trig       = fetch_en && (x == 10'(H_ACTIVE)) && (line_next < 10'(V_ACTIVE));
    assign start_addr = (line_next == 10'd0) ? ADDR_W'(FB_BASE) : next_base;

    assign bus.cli_rdata = bus.mem_rdata;
    assign bus.lb_wdata  = bus.mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            idx           <= '0;
            next_base     <= ADDR_W'(FB_BASE);
            fetch_start   <= '0;
            bus.cli_gnt   <= 1'b0;
            bus.cli_rvalid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.lb_we     <= 1'b0;
            bus.lb_bank   <= 1'b0;
            bus.lb_addr   <= '0;
            fetch_busy    <= 1'b0;
            fetch_done    <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            bus.cli_gnt    <= 1'b0;
            bus.mem_re     <= 1'b0;
            bus.mem_we     <= 1'b0;
            fetch_done     <= 1'b0;
            err_overrun    <= 1'b0;
            // line-buffer write trails the memory read by the RAM's one-cycle latency
            bus.lb_we      <= (state == FETCH);
            bus.lb_addr    <= idx;
            bus.cli_rvalid <= (state == CLIENT) && bus.mem_re;

            case (state)
                IDLE, CLIENT: begin
                    if (trig || (state == IDLE && pending)) begin
                        state        <= FETCH;
                        pending      <= pending | (state == CLIENT);
                        idx          <= '0;
                        fetch_start  <= start_addr;
                        bus.mem_addr <= start_addr;
                        bus.mem_re   <= 1'b1;
                        bus.lb_bank  <= line_next[0];
                        fetch_busy   <= 1'b1;
                    end else if (state == IDLE && bus.cli_req) begin
                        state         <= CLIENT;
                        bus.cli_gnt   <= 1'b1;
                        bus.mem_addr  <= bus.cli_addr;
                        bus.mem_we    <= bus.cli_we;
                        bus.mem_re    <= !bus.cli_we;
                        bus.mem_wdata <= bus.cli_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    err_overrun <= trig;
                    if (idx == LB_AW'(LINE_WORDS - 1)) begin
                        state      <= DRAIN;
                        fetch_done <= 1'b1;
                    end else begin
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                        idx          <= idx + LB_AW'(1);
                    end
                end
                DRAIN: begin
                    err_overrun <= trig;
                    next_base   <= fetch_start + ADDR_W'(LINE_WORDS);
                    pending     <= 1'b0;
                    fetch_busy  <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// tb/tb_vga_fb_fetch_arbiter.sv - directed bench with a cycle-level reference model of the arbiter
module tb_vga_fb_fetch_arbiter;
    localparam int LW = 50;

    logic       clk;
    logic       reset_n;
    logic [9:0] x;
    logic [9:0] y;
    logic       fetch_en;
    logic       fetch_busy;
    logic       fetch_done;
    logic       err_overrun;

    vga_fb_fetch_arbiter_if #(.ADDR_W(16), .DATA_W(16), .LB_AW(6)) bus ();

    vga_fb_fetch_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .fetch_en   (fetch_en),
        .bus        (bus),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .err_overrun(err_overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fdat(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // framebuffer RAM: data is a fixed function of the address, one cycle after mem_re
    logic [15:0] rd_next;
    always @(negedge clk) rd_next = bus.mem_re ? fdat(bus.mem_addr) : 16'h0;
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = rd_next;
    end

    // reference model: m_ft is the cycle number within a line fetch, -1 when none is running
    logic [9:0]  ln;
    logic        trig;
    assign ln   = (y == 10'd627) ? 10'd0 : y + 10'd1;
    assign trig = fetch_en && (x == 10'd800) && (ln < 10'd600);

    int          m_ft;
    logic        m_cli, m_we, m_bank, m_err, m_rv;
    logic [15:0] m_addr, m_wdata, m_start, m_nb, m_rv_addr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ft <= -1; m_cli <= 1'b0; m_we <= 1'b0; m_bank <= 1'b0;
            m_err <= 1'b0; m_rv <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_start <= '0; m_nb <= '0; m_rv_addr <= '0;
        end else begin
            m_err     <= (m_ft >= 0) && trig;
            m_rv      <= m_cli && !m_we;
            m_rv_addr <= m_addr;
            if (m_ft >= 0) begin
                m_cli <= 1'b0;
                if (m_ft == LW) begin
                    m_ft <= -1;
                    m_nb <= m_start + 16'(LW);
                end else begin
                    m_ft <= m_ft + 1;
                end
            end else if (trig) begin
                m_ft    <= 0;
                m_cli   <= 1'b0;
                m_start <= (ln == 10'd0) ? 16'h0 : m_nb;
                m_bank  <= ln[0];
            end else if (m_cli) begin
                m_cli <= 1'b0;
            end else if (bus.cli_req) begin
                m_cli   <= 1'b1;
                m_we    <= bus.cli_we;
                m_addr  <= bus.cli_addr;
                m_wdata <= bus.cli_wdata;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_fetch, e_re, e_we, e_lbwe;
        logic [15:0] e_addr;
        e_fetch = (m_ft >= 0) && (m_ft < LW);
        e_re    = e_fetch || (m_cli && !m_we);
        e_we    = m_cli && m_we;
        e_lbwe  = (m_ft >= 1) && (m_ft <= LW);
        e_addr  = e_fetch ? m_start + 16'(m_ft) : m_addr;
        check("mem_re", 32'(bus.mem_re), 32'(e_re));
        check("mem_we", 32'(bus.mem_we), 32'(e_we));
        check("cli_gnt", 32'(bus.cli_gnt), 32'(m_cli));
        check("cli_rvalid", 32'(bus.cli_rvalid), 32'(m_rv));
        check("fetch_busy", 32'(fetch_busy), 32'(m_ft >= 0));
        check("fetch_done", 32'(fetch_done), 32'(m_ft == LW));
        check("err_overrun", 32'(err_overrun), 32'(m_err));
        check("lb_we", 32'(bus.lb_we), 32'(e_lbwe));
        if (e_re || e_we) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        if (e_lbwe) begin
            check("lb_addr", 32'(bus.lb_addr), 32'(m_ft - 1));
            check("lb_wdata", 32'(bus.lb_wdata), 32'(fdat(m_start + 16'(m_ft - 1))));
        end
        if (m_ft >= 0) check("lb_bank", 32'(bus.lb_bank), 32'(m_bank));
        if (m_rv) check("cli_rdata", 32'(bus.cli_rdata), 32'(fdat(m_rv_addr)));
    end

    task automatic run_fetch(input logic [9:0] yv, input logic [15:0] exp_start,
                             input logic exp_bank, input bit ovr);
        int re_cnt;
        re_cnt = 0;
        y = yv;
        x = 10'd800;
        cyc();
        x = 10'd0;
        for (int i = 0; i <= LW; i++) begin
            if (i == 0) begin
                check("first_addr", 32'(bus.mem_addr), 32'(exp_start));
                check("busy_start", 32'(fetch_busy), 32'd1);
            end
            if (i == LW - 1) check("last_addr", 32'(bus.mem_addr), 32'(exp_start + 16'd49));
            if (ovr && i == 11) check("overrun_pulse", 32'(err_overrun), 32'd1);
            if (ovr && i == 12) check("overrun_clear", 32'(err_overrun), 32'd0);
            if (i == LW) begin
                check("done_pulse", 32'(fetch_done), 32'd1);
                check("drain_lb_we", 32'(bus.lb_we), 32'd1);
                check("drain_lb_addr", 32'(bus.lb_addr), 32'd49);
                check("drain_lb_bank", 32'(bus.lb_bank), 32'(exp_bank));
            end
            re_cnt += 32'(bus.mem_re);
            x = (ovr && i == 10) ? 10'd800 : 10'd0;
            cyc();
        end
        check("re_count", 32'(re_cnt), 32'(LW));
        check("idle_after", 32'(fetch_busy), 32'd0);
    endtask

    initial begin
        int waited;
        reset_n = 1'b1;
        x = '0; y = '0; fetch_en = 1'b0;
        bus.cli_req = 1'b0; bus.cli_we = 1'b0; bus.cli_addr = '0; bus.cli_wdata = '0;
        bus.mem_rdata = '0;
        #1 reset_n = 1'b0;

        for (int i = 0; i < 5; i++) begin
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
            fetch_en = 1'($urandom);
            bus.cli_req = 1'($urandom); bus.cli_we = 1'($urandom);
            bus.cli_addr = 16'($urandom); bus.cli_wdata = 16'($urandom);
            cyc();
            check("rst_mem", {bus.mem_re, bus.mem_we, bus.mem_addr, 14'd0}, 32'd0);
            check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
            check("rst_cli", {bus.cli_gnt, bus.cli_rvalid, bus.cli_rdata, 14'd0}, 32'd0);
            check("rst_lb", {bus.lb_we, bus.lb_bank, bus.lb_addr, bus.lb_wdata}, 32'd0);
            check("rst_flags", {fetch_busy, fetch_done, err_overrun}, 32'd0);
        end
        x = '0; y = '0; fetch_en = 1'b1; bus.cli_req = 1'b0;
        reset_n = 1'b1;
        repeat (3) cyc();
        check("post_rst_strobes", {bus.mem_re, bus.mem_we}, 32'd0);

        run_fetch(10'd4, 16'd0, 1'b1, 1'b0);
        run_fetch(10'd5, 16'd50, 1'b0, 1'b1);
        run_fetch(10'd627, 16'd0, 1'b0, 1'b0);

        y = 10'd599; x = 10'd800; cyc(); x = 10'd0; cyc();
        check("no_fetch_599", {fetch_busy, bus.mem_re}, 32'd0);
        fetch_en = 1'b0; y = 10'd10; x = 10'd800; cyc(); x = 10'd0; cyc();
        check("no_fetch_disabled", {fetch_busy, bus.mem_re}, 32'd0);
        fetch_en = 1'b1;

        bus.cli_req = 1'b1; bus.cli_we = 1'b0; bus.cli_addr = 16'h1234;
        cyc();
        check("rd_gnt", 32'(bus.cli_gnt), 32'd1);
        check("rd_addr", 32'(bus.mem_addr), 32'h1234);
        check("rd_re", 32'(bus.mem_re), 32'd1);
        bus.cli_req = 1'b0;
        cyc();
        check("rd_rvalid", 32'(bus.cli_rvalid), 32'd1);
        check("rd_data", 32'(bus.cli_rdata), 32'h4808);

        bus.cli_req = 1'b1; bus.cli_we = 1'b1; bus.cli_addr = 16'h0BEE; bus.cli_wdata = 16'hCAFE;
        cyc();
        check("wr_strobes", {bus.cli_gnt, bus.mem_we, bus.mem_re}, 32'b110);
        check("wr_data", 32'(bus.mem_wdata), 32'hCAFE);
        bus.cli_req = 1'b0;
        cyc();
        check("wr_no_rvalid", 32'(bus.cli_rvalid), 32'd0);

        bus.cli_req = 1'b1; bus.cli_we = 1'b0; bus.cli_addr = 16'h0042;
        y = 10'd20; x = 10'd800;
        cyc();
        x = 10'd0;
        check("cont_fetch_first", {bus.cli_gnt, fetch_busy, bus.mem_re}, 32'b011);
        check("cont_addr", 32'(bus.mem_addr), 32'd50);
        waited = 0;
        while (!bus.cli_gnt && waited < 100) begin
            cyc();
            waited++;
        end
        check("gnt_after_drain", 32'(waited), 32'd52);
        bus.cli_req = 1'b0;
        cyc(); cyc();

        bus.cli_req = 1'b1; bus.cli_addr = 16'h0077;
        cyc();
        check("cli_trig_gnt", 32'(bus.cli_gnt), 32'd1);
        bus.cli_req = 1'b0; y = 10'd30; x = 10'd800;
        cyc();
        x = 10'd0;
        check("cli_trig_fetch", {fetch_busy, bus.mem_re, bus.cli_rvalid}, 32'b111);
        check("cli_trig_addr", 32'(bus.mem_addr), 32'd100);
        check("cli_trig_rdata", 32'(bus.cli_rdata), 32'h5A4B);
        repeat (LW + 2) cyc();

        y = 10'd40; x = 10'd800; cyc(); x = 10'd0;
        repeat (20) cyc();
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {fetch_busy, bus.mem_re, bus.lb_we, fetch_done, bus.lb_addr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("abort_no_done", 32'(fetch_done), 32'd0);
        end
        reset_n = 1'b1;
        cyc();
        run_fetch(10'd6, 16'd0, 1'b1, 1'b0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
